dsm_param: RTL and testbench
============================

# dsm_param

Parametrised delta-sigma modulator, the successor to the fixed 20-bit first-order DSM. It converts an unsigned WIDTH-bit sample stream into a 1-bit PWM/PDM bitstream. The loop order is selectable (1 or 2), and an internal oversampling counter paces input requests through a valid/ready handshake. It sits between the sample source (FIFO or DSP front end) and the output pin driver.

## Interface
- WIDTH, 20: input sample width in bits, range 4..24.
- ORDER, 1: loop order, 1 or 2; any other value is an elaboration error.
- OSR, 64: clocks per input sample, range 2..65535.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clock.
- vin  input  WIDTH  unsigned input sample.
- vin_valid  input  1  vin holds a valid sample.
- vin_ready  output  1  block requests a sample this cycle.
- underrun_clr  input  1  clears the underrun flag.
- pwm  output  1  modulated bitstream, registered.
- underrun  output  1  sticky flag: a request went unanswered.

## Operation
- Reset values:
  - pwm 0, underrun 0, vin_ready 0.
  - Held sample 0, OSR counter 0, integrators 0.
  - LFSR at its seed value (dither build only).
- OSR counter: counts 0..OSR-1, wraps to 0, and never stops.
- vin_ready: 1 exactly when the counter equals OSR-1; it is a decode of the registered count.
- Sample acceptance:
  - When vin_valid and vin_ready are both 1, the held sample loads vin at that edge.
  - vin_valid outside a vin_ready cycle is ignored and the held sample is unchanged.
- Underrun:
  - vin_ready with vin_valid low sets underrun at that edge.
  - The held sample is reused.
  - underrun_clr clears the flag. If a set and a clear occur in the same cycle, the set wins.
- Modulator input: x = held sample, zero-extended.
- Modulator steps every clock.
- ORDER=1 (error feedback):
  - sum = acc + x, WIDTH+1 bits.
  - pwm <= sum[WIDTH]; acc <= sum[WIDTH-1:0].
- ORDER=2:
  - Integrators i1, i2 are signed, WIDTH+4 bits. fb = pwm ? 2^WIDTH : 0, using the registered pwm.
  - i1n = i1 + x - fb; i2n = i2 + i1n - fb.
  - Each of i1n and i2n saturates to [-2^(WIDTH+2), 2^(WIDTH+2)-1] before it is registered.
  - pwm <= (i2n >= 2^(WIDTH-1)).
- Long-run pwm density = x / 2^WIDTH in both orders.

## Timing
- Sample accepted at edge k. The held register updates at k, and the modulator first uses the new value at edge k+1, where pwm reflects it.
- First vin_ready occurs in the cycle after the OSR-1th rising edge following reset deassertion.
- pwm changes only on rising edges, with no combinational path from any input.
- Asynchronous reset mid-stream immediately forces every output and all state to the reset values listed above. The OSR phase restarts from 0.

## Configuration
- DSM_PARAM_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) steps every clock.
  - The modulator uses x = held + lfsr[0], saturated at 2^WIDTH-1.
  - This breaks up idle tones.
- DSM_PARAM_DITHER_EN undefined:
  - No LFSR is built and x = held.
  - Bitstreams are fully deterministic and are used by the golden-vector benches.

## Structure
- Shared package dsm_pkg holds:
  - the LFSR seed and tap constants;
  - the legal ORDER values as localparams;
  - a saturate function parametrised on width.
- Sub-module dsm_lfsr holds the dither generator, instantiated only under DSM_PARAM_DITHER_EN.
- The order-1 and order-2 datapaths are generate branches in dsm_param, not separate modules.

## Test plan
All scenarios below use the non-dither build.
- Order-1 midscale: WIDTH=20, ORDER=1, OSR=4, vin=20'h80000 supplied on every request. After the sample is loaded, pwm alternates 0,1,0,1…; 1000 cycles contain 500±1 ones.
- Order-1 extremes:
  - vin=0: pwm stays 0.
  - vin=20'hFFFFF: exactly one 0 in every 2^20 cycles.
  - WIDTH=8 variant, vin=8'hFF: one 0 per 256 cycles.
- Handshake timing, OSR=8: vin_ready pulses on cycles 7, 15, 23… after reset release. A sample is accepted only on pulse cycles, and pwm density changes starting one cycle after acceptance.
- Underrun: hold vin_valid low at one vin_ready pulse. underrun rises at that edge and pwm keeps the previous density. Asserting underrun_clr in the same cycle as a second miss leaves underrun at 1.
- Order-2 density and saturation: WIDTH=12, ORDER=2, vin=12'h400 gives a density of 0.25±0.002 over 16384 cycles. Stepping vin from 0 to 12'hFFF leaves the integrators within the saturation bounds with no wrap, checked by an assertion.
- Reset mid-stream: assert reset during an active bitstream. All outputs read 0 in the same cycle. After release, the first vin_ready arrives OSR-1 cycles later.

Source files
------------

// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsm_pkg
// Purpose  : Shared constants and helpers for the dsm_param modulator family.
// Revision : 1.0 - initial release
// ============================================================================
package dsm_pkg;

    // Right-shift Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'h002D;

    localparam int c_order_first  = 1;
    localparam int c_order_second = 2;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_param_if.sv
`default_nettype none
// ============================================================================
// Module   : dsm_param_if
// Purpose  : Sample handshake between a sample source and the modulator.
// Revision : 1.0 - initial release
// ============================================================================
interface dsm_param_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] vin;
    logic             vin_valid;
    logic             vin_ready;

    modport master (output vin, output vin_valid, input vin_ready);
    modport slave  (input vin, input vin_valid, output vin_ready);
endinterface
`default_nettype wire

// File: rtl/dsm_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dsm_lfsr
// Purpose  : 16-bit Fibonacci LFSR dither source, stepping every clock.
// Revision : 1.0 - initial release
// ============================================================================
module dsm_lfsr
    import dsm_pkg::*;
(
    input  wire logic        clock,
    input  wire logic        reset,
    output logic [15:0]      o_lfsr
);
    logic [15:0] r_lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_lfsr <= c_lfsr_seed;
        else
            r_lfsr <= {^(r_lfsr & c_lfsr_taps), r_lfsr[15:1]};
    end

    assign o_lfsr = r_lfsr;
endmodule
`default_nettype wire

// File: rtl/dsm_param.sv
`default_nettype none
// ============================================================================
// Module   : dsm_param
// Purpose  : Order-1/2 delta-sigma modulator, OSR-paced sample requests.
//            Optional LFSR dither enabled by defining DSM_PARAM_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dsm_param
    import dsm_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int ORDER = 1,
    parameter int OSR   = 64
) (
    input  wire logic   clock,
    input  wire logic   reset,
    dsm_param_if.slave  s_in,
    input  wire logic   underrun_clr,
    output logic        pwm,
    output logic        underrun
);
    localparam int                 c_cnt_w    = $clog2(OSR);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OSR - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_held;
    logic               r_underrun;
    logic               r_pwm;
    logic               w_ready;
    logic [WIDTH-1:0]   w_x;

    assign w_ready        = (r_cnt == c_cnt_last);
    assign s_in.vin_ready = w_ready;
    assign pwm            = r_pwm;
    assign underrun       = r_underrun;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_held     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt <= w_ready ? '0 : r_cnt + 1'b1;
            if (w_ready && s_in.vin_valid)
                r_held <= s_in.vin;
            // A missed request in the same cycle as a clear keeps the flag set
            if (w_ready && !s_in.vin_valid)
                r_underrun <= 1'b1;
            else if (underrun_clr)
                r_underrun <= 1'b0;
        end
    end

`ifdef DSM_PARAM_DITHER_EN
    logic [15:0]    w_lfsr;
    logic [WIDTH:0] w_dith;

    dsm_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .o_lfsr (w_lfsr)
    );

    assign w_dith = {1'b0, r_held} + {{WIDTH{1'b0}}, w_lfsr[0]};
    assign w_x    = w_dith[WIDTH] ? '1 : w_dith[WIDTH-1:0];
`else
    assign w_x = r_held;
`endif

    if (ORDER == c_order_first) begin : g_order1
        logic [WIDTH-1:0] r_acc;
        logic [WIDTH:0]   w_sum;

        assign w_sum = {1'b0, r_acc} + {1'b0, w_x};

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_acc <= '0;
                r_pwm <= 1'b0;
            end else begin
                r_acc <= w_sum[WIDTH-1:0];
                r_pwm <= w_sum[WIDTH];
            end
        end
    end else if (ORDER == c_order_second) begin : g_order2
        // Extra headroom so unsaturated sums can never wrap before clamping
        localparam int                     c_iw   = WIDTH + 4;
        localparam int                     c_ew   = WIDTH + 7;
        localparam logic signed [c_ew-1:0] c_full = c_ew'(2 ** WIDTH);
        localparam logic signed [c_ew-1:0] c_half = c_ew'(2 ** (WIDTH - 1));

        logic signed [c_iw-1:0] r_i1;
        logic signed [c_iw-1:0] r_i2;
        logic signed [c_ew-1:0] w_xe;
        logic signed [c_ew-1:0] w_fb;
        logic signed [c_ew-1:0] w_i1n;
        logic signed [c_ew-1:0] w_i2n;

        assign w_xe  = c_ew'(w_x);
        assign w_fb  = r_pwm ? c_full : '0;
        assign w_i1n = c_ew'(r_i1) + w_xe - w_fb;
        assign w_i2n = c_ew'(r_i2) + w_i1n - w_fb;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_i1  <= '0;
                r_i2  <= '0;
                r_pwm <= 1'b0;
            end else begin
                r_i1  <= c_iw'(sat_signed(64'(w_i1n), c_iw - 1));
                r_i2  <= c_iw'(sat_signed(64'(w_i2n), c_iw - 1));
                r_pwm <= (w_i2n >= c_half);
            end
        end
    end else begin : g_order_bad
        $error("dsm_param: ORDER must be 1 or 2");
    end

endmodule
`default_nettype wire

// File: tb/tb_dsm_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsm_param
// Purpose  : Self-checking bench: order-1 (8-bit) and order-2 (12-bit)
//            modulators against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm_param;

    localparam int c_wa  = 8;
    localparam int c_wb  = 12;
    localparam int c_osr = 8;
    localparam longint c_blo = -(64'sd1 <<< (c_wb + 2));
    localparam longint c_bhi = (64'sd1 <<< (c_wb + 2)) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dsm_param_if #(.WIDTH(c_wa)) if_a ();
    dsm_param_if #(.WIDTH(c_wb)) if_b ();
    logic clr_a, clr_b, pwm_a, pwm_b, und_a, und_b;

    dsm_param #(.WIDTH(c_wa), .ORDER(1), .OSR(c_osr)) dut_a (
        .clock(clock), .reset(reset), .s_in(if_a), .underrun_clr(clr_a),
        .pwm(pwm_a), .underrun(und_a));

    dsm_param #(.WIDTH(c_wb), .ORDER(2), .OSR(c_osr)) dut_b (
        .clock(clock), .reset(reset), .s_in(if_b), .underrun_clr(clr_b),
        .pwm(pwm_b), .underrun(und_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: time since reset release plus loop state
    longint t;
    longint m_held_a, m_acc_a, m_held_b, m_i1, m_i2;
    bit     m_pwm_a, m_pwm_b, m_und_a, m_und_b;

    // Stimulus selection
    bit             rnd;
    logic [c_wa-1:0] sa_vin;
    logic [c_wb-1:0] sb_vin;
    bit sa_valid, sb_valid, sa_clr, sb_clr;

    function automatic bit m_ready();
        return (t % c_osr) == (c_osr - 1);
    endfunction

    function automatic longint clamp(input longint v);
        if (v > c_bhi) return c_bhi;
        if (v < c_blo) return c_blo;
        return v;
    endfunction

    task automatic model_reset();
        t = 0;
        m_held_a = 0; m_acc_a = 0; m_pwm_a = 0; m_und_a = 0;
        m_held_b = 0; m_i1 = 0; m_i2 = 0; m_pwm_b = 0; m_und_b = 0;
    endtask

    task automatic model_step();
        bit     rdy;
        longint s, fb, i1n, i2n;
        rdy = m_ready();
        s       = m_acc_a + m_held_a;
        m_pwm_a = (s >= (64'sd1 <<< c_wa));
        m_acc_a = s % (64'sd1 <<< c_wa);
        fb      = m_pwm_b ? (64'sd1 <<< c_wb) : 0;
        i1n     = m_i1 + m_held_b - fb;
        i2n     = m_i2 + i1n - fb;
        m_pwm_b = (i2n >= (64'sd1 <<< (c_wb - 1)));
        m_i1    = clamp(i1n);
        m_i2    = clamp(i2n);
        if (rdy && sa_valid) m_held_a = sa_vin;
        if (rdy && sb_valid) m_held_b = sb_vin;
        if (rdy && !sa_valid) m_und_a = 1; else if (sa_clr) m_und_a = 0;
        if (rdy && !sb_valid) m_und_b = 1; else if (sb_clr) m_und_b = 0;
        t++;
    endtask

    task automatic compare();
        check("a_pwm", pwm_a, m_pwm_a);
        check("a_ready", if_a.vin_ready, m_ready());
        check("a_underrun", und_a, m_und_a);
        check("b_pwm", pwm_b, m_pwm_b);
        check("b_ready", if_b.vin_ready, m_ready());
        check("b_underrun", und_b, m_und_b);
        check("b_i1_bound", (longint'(dut_b.g_order2.r_i1) >= c_blo) &&
                            (longint'(dut_b.g_order2.r_i1) <= c_bhi), 1);
        check("b_i2_bound", (longint'(dut_b.g_order2.r_i2) >= c_blo) &&
                            (longint'(dut_b.g_order2.r_i2) <= c_bhi), 1);
    endtask

    task automatic cycle();
        if (rnd) begin
            sa_vin   = c_wa'($urandom);
            sb_vin   = c_wb'($urandom);
            sa_valid = ($urandom % 4) != 0;
            sb_valid = ($urandom % 4) != 0;
            sa_clr   = ($urandom % 8) == 0;
            sb_clr   = ($urandom % 8) == 0;
        end
        if_a.vin = sa_vin; if_a.vin_valid = sa_valid; clr_a = sa_clr;
        if_b.vin = sb_vin; if_b.vin_valid = sb_valid; clr_b = sb_clr;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic to_ready();
        for (int k = 0; k < 2 * c_osr; k++) begin
            if (m_ready()) break;
            cycle();
        end
        check("reach_ready", if_a.vin_ready, 1);
    endtask

    initial begin
        int ones_a, ones_b, zeros_a, n;
        rnd = 0;
        sa_vin = '0; sb_vin = '0; sa_valid = 0; sb_valid = 0; sa_clr = 0; sb_clr = 0;
        if_a.vin = '0; if_a.vin_valid = 0; clr_a = 0;
        if_b.vin = '0; if_b.vin_valid = 0; clr_b = 0;
        model_reset();
        #1 reset = 1'b0;
        #1;
        check("rst_a_pwm", pwm_a, 0);     check("rst_a_ready", if_a.vin_ready, 0);
        check("rst_a_und", und_a, 0);     check("rst_b_pwm", pwm_b, 0);
        check("rst_b_ready", if_b.vin_ready, 0); check("rst_b_und", und_b, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Midscale (order 1) and quarter scale (order 2)
        sa_vin = 8'h80; sa_valid = 1; sb_vin = 12'h400; sb_valid = 1;
        repeat (16) cycle();
        ones_a = 0; ones_b = 0;
        for (int i = 0; i < 16384; i++) begin
            cycle();
            if (i < 1000) ones_a += int'(pwm_a);
            ones_b += int'(pwm_b);
        end
        check("a_mid_density", (ones_a >= 499) && (ones_a <= 501), 1);
        check("b_quarter_density", (ones_b >= 4063) && (ones_b <= 4129), 1);

        // Full scale order 1: exactly one zero per 256 cycles; order 2 parked at 0
        sa_vin = 8'hFF; sb_vin = '0;
        repeat (16) cycle();
        zeros_a = 0;
        for (int i = 0; i < 512; i++) begin
            cycle();
            zeros_a += int'(!pwm_a);
        end
        check("a_full_zeros", zeros_a, 2);

        // Zero input order 1; order 2 steps to full scale and must stay bounded
        sa_vin = '0; sb_vin = 12'hFFF;
        repeat (16) cycle();
        ones_a = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            ones_a += int'(pwm_a);
        end
        check("a_zero_ones", ones_a, 0);

        // Underrun set, clear, then set-wins-over-clear
        sa_vin = 8'h40; sb_vin = 12'h800;
        to_ready();
        sa_valid = 0;
        cycle();
        check("a_underrun_set", und_a, 1);
        sa_valid = 1; sa_clr = 1;
        cycle();
        check("a_underrun_clr", und_a, 0);
        sa_clr = 0;
        to_ready();
        sa_valid = 0; sa_clr = 1;
        cycle();
        check("a_underrun_set_wins", und_a, 1);
        sa_valid = 1; sa_clr = 0;

        // Randomised handshake traffic
        rnd = 1;
        repeat (2000) cycle();
        rnd = 0;

        // Reset in the middle of an active bitstream
        sa_vin = 8'h80; sa_valid = 1; sa_clr = 0; sb_valid = 1; sb_clr = 0;
        repeat (16) cycle();
        for (int k = 0; k < 4; k++) begin
            if (pwm_a) break;
            cycle();
        end
        check("pre_reset_pwm", pwm_a, 1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_a_pwm", pwm_a, 0);   check("mid_rst_a_ready", if_a.vin_ready, 0);
        check("mid_rst_a_und", und_a, 0);   check("mid_rst_b_pwm", pwm_b, 0);
        check("mid_rst_b_ready", if_b.vin_ready, 0); check("mid_rst_b_und", und_b, 0);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            n = k;
            if (if_a.vin_ready) break;
        end
        check("ready_latency", n, c_osr - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
